// File: rtl/base_rr_arb_reg.sv
// rtl/base_rr_arb_reg.sv - round-robin arbitrated holding register
// Shares one registered output among `ways` valid/ready requesters with rotating priority.
module base_rr_arb_reg #(
  parameter int ways  = 4,
  parameter int width = 8,
  parameter int idxw  = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ways-1:0]        i_v,
  output logic [ways-1:0]        i_r,
  input  logic [ways*width-1:0]  i_d,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [width-1:0]       o_d,
  output logic [idxw-1:0]        o_src
);

  localparam logic [idxw:0]   ways_c = (idxw+1)'(ways);
  localparam logic [idxw-1:0] last_c = idxw'(ways - 1);

  logic [idxw-1:0]  ptr;
  logic [idxw-1:0]  g;
  logic             hit;
  logic             ld;
  logic             acc;
  logic [idxw:0]    sum;
  logic [width-1:0] d_arr [ways];

  for (genvar k = 0; k < ways; k++) begin : g_slice
    assign d_arr[k] = i_d[k*width +: width];
  end

  assign ld  = ~o_v | o_r;
  assign acc = hit & ld & ~reset;

  // Scan from the farthest offset down so the nearest valid requester to ptr wins.
  always_comb begin
    hit = 1'b0;
    g   = '0;
    sum = '0;
    for (int j = ways - 1; j >= 0; j--) begin
      sum = {1'b0, ptr} + (idxw+1)'(j);
      if (sum >= ways_c) sum = sum - ways_c;
      if (i_v[sum[idxw-1:0]]) begin
        hit = 1'b1;
        g   = sum[idxw-1:0];
      end
    end
  end

  always_comb begin
    i_r = '0;
    if (acc) i_r[g] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_v   <= 1'b0;
      o_d   <= '0;
      o_src <= '0;
      ptr   <= '0;
    end else if (acc) begin
      o_v   <= 1'b1;
      o_d   <= d_arr[g];
      o_src <= g;
      ptr   <= (g == last_c) ? '0 : g + 1'b1;
    end else if (o_r) begin
      o_v   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_base_rr_arb_reg.sv
// tb/tb_base_rr_arb_reg.sv - directed and scoreboarded checks for base_rr_arb_reg
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_base_rr_arb_reg;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_v;
  logic [3:0]  i_r;
  logic [31:0] i_d;
  logic        o_v;
  logic        o_r;
  logic [7:0]  o_d;
  logic [1:0]  o_src;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] word [4];
  bit         pend [4];
  int         waits [4];
  int         seq;
  logic [9:0] q [$];
  int         mptr;
  bit         mo_v;
  int         gexp;
  int         kk;
  logic [3:0] eir;

  always #5 clk = ~clk;

  base_rr_arb_reg #(.ways(4), .width(8)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_src(o_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_v = 4'h0; o_r = 1'b0; i_d = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(negedge clk);
    chk("rst_o_v", o_v, 0);
    chk("rst_o_src", o_src, 0);
    chk("rst_o_d", o_d, 0);
    chk("rst_ptr", dut.ptr, 0);
    i_v = 4'hF; #1;
    chk("rst_i_r", i_r, 0);

    @(negedge clk); reset = 1'b0; i_v = 4'h0; o_r = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_o_v", o_v, 0);
    chk("idle_ptr", dut.ptr, 0);

    i_v = 4'hF; #1;
    chk("rot_i_r0", i_r, 4'b0001);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("rot_o_v", o_v, 1);
      chk("rot_o_src", o_src, n % 4);
      chk("rot_o_d", o_d, 8'h10 + n % 4);
    end
    chk("rot_ptr", dut.ptr, 0);

    i_v = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("skip_o_src", o_src, (n % 2 == 0) ? 1 : 3);
    end
    i_v = 4'b0001;
    @(negedge clk);
    chk("skip0_o_src", o_src, 0);
    chk("skip0_ptr", dut.ptr, 1);

    i_v = 4'b0010; i_d[15:8] = 8'hA5;
    @(negedge clk);
    chk("bp_load_o_d", o_d, 8'hA5);
    chk("bp_load_ptr", dut.ptr, 2);
    o_r = 1'b0; i_v = 4'hF; #1;
    chk("bp_i_r0", i_r, 0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_i_r", i_r, 0);
      chk("bp_o_d", o_d, 8'hA5);
      chk("bp_o_v", o_v, 1);
      chk("bp_o_src", o_src, 1);
    end
    o_r = 1'b1; #1;
    chk("bp_rel_i_r", i_r, 4'b0100);
    @(negedge clk);
    chk("bp_rel_o_v", o_v, 1);
    chk("bp_rel_o_src", o_src, 2);
    chk("bp_rel_o_d", o_d, 8'h12);
    chk("bp_rel_ptr", dut.ptr, 3);

    i_v = 4'b0100; i_d[23:16] = 8'h3C;
    @(negedge clk);
    chk("df_o_v", o_v, 1);
    chk("df_o_d", o_d, 8'h3C);
    chk("df_o_src", o_src, 2);
    chk("df_ptr", dut.ptr, 3);

    i_v = 4'h0;
    @(negedge clk);
    chk("drain_o_v", o_v, 0);
    chk("drain_o_d", o_d, 8'h3C);
    chk("drain_o_src", o_src, 2);

    i_v = 4'b0010; o_r = 1'b0;
    @(negedge clk);
    chk("mid_o_v", o_v, 1);
    chk("mid_o_src", o_src, 1);
    #2 reset = 1'b1; #1;
    chk("mid_rst_o_v", o_v, 0);
    chk("mid_rst_o_src", o_src, 0);
    chk("mid_rst_i_r", i_r, 0);
    chk("mid_rst_ptr", dut.ptr, 0);
    @(negedge clk); reset = 1'b0; i_v = 4'b1010; o_r = 1'b1; #1;
    chk("post_rst_i_r", i_r, 4'b0010);
    @(negedge clk);
    chk("post_rst_o_src", o_src, 1);
    chk("post_rst_ptr", dut.ptr, 2);
    i_v = 4'h0;
    @(negedge clk);
    chk("pre_rnd_o_v", o_v, 0);

    mptr = 2; mo_v = 1'b0; seq = 0;
    for (int k = 0; k < 4; k++) begin pend[k] = 1'b0; waits[k] = 0; word[k] = 8'h00; end
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(1, 0) == 1) begin
          pend[k] = 1'b1;
          word[k] = {k[1:0], seq[5:0]};
          seq++;
        end
      end
      i_v = {pend[3], pend[2], pend[1], pend[0]};
      i_d = {word[3], word[2], word[1], word[0]};
      o_r = ($urandom_range(3, 0) != 0);
      #1;
      gexp = -1;
      for (int j = 0; j < 4; j++) begin
        kk = (mptr + j) % 4;
        if (gexp < 0 && pend[kk]) gexp = kk;
      end
      eir = 4'h0;
      if (gexp >= 0 && (!mo_v || o_r)) eir[gexp] = 1'b1;
      chk("rnd_i_r", i_r, eir);
      chk("rnd_o_v", o_v, mo_v);
      if (mo_v && o_r) begin
        chk("rnd_out", {o_src, o_d}, q[0]);
        q.pop_front();
      end
      if (eir != 4'h0) begin
        chk("rnd_wait", waits[gexp] <= 4, 1);
        for (int k = 0; k < 4; k++) if (pend[k] && k != gexp) waits[k]++;
        waits[gexp] = 0;
        pend[gexp] = 1'b0;
        q.push_back({gexp[1:0], word[gexp]});
        mptr = (gexp + 1) % 4;
        mo_v = 1'b1;
      end else if (mo_v && o_r) begin
        mo_v = 1'b0;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/base_rr_arb_reg.md
# base_rr_arb_reg

Round-robin arbitrated holding register. Shares one output register stage among `ways` valid/ready requesters, granting one requester per accepted transfer in rotating priority order. Sits in front of any single-consumer datapath that multiple producers must share, such as a shared command or result bus. Provides a registered output with full throughput of one transfer per cycle.

## Interface
- `ways`, default 4, number of requesters; legal range 2..16.
- `width`, default 8, data width per requester.
- `idxw`, default `$clog2(ways)`, width of the source index; a minimum of 1 is enforced.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_v`  in  ways  per-requester valid; bit k belongs to requester k.
- `i_r`  out  ways  per-requester ready; at most one bit is set in any cycle.
- `i_d`  in  ways*width  requester data; requester k occupies bits [k*width +: width].
- `o_v`  out  1  output register holds valid data.
- `o_r`  in  1  consumer ready.
- `o_d`  out  width  registered data.
- `o_src`  out  idxw  index of the requester that supplied `o_d`.

## Operation
- State:
  - `o_v`, `o_d` and `o_src` registers.
  - Priority pointer `ptr` (idxw bits, value 0..ways-1). It names the highest-priority requester.
- Reset values:
  - `o_v`=0, `o_d`=0, `o_src`=0, `ptr`=0.
  - `i_r`=0 while `reset` is asserted.
- Load enable: `ld = ~o_v | o_r`. The register is empty, or it is being drained this cycle.
- Selection, combinational:
  - Scan k = ptr, ptr+1, … modulo ways.
  - The first k with `i_v[k]`=1 is the winner `g`.
  - If there is no valid requester, there is no winner.
- Ready: `i_r[g] = ld` for the winner only. All other bits of `i_r` are 0.
- Transfer from requester g: occurs when `i_v[g] & i_r[g]`. On the next edge:
  - `o_v`←1.
  - `o_d`←slice g of `i_d`.
  - `o_src`←g.
  - `ptr`←(g+1) mod ways. This includes wrap-around from ways-1 to 0.
- Output transfer: occurs when `o_v & o_r`.
  - If a transfer from a requester happens in the same cycle, the register reloads. `o_v` stays 1 (simultaneous drain and fill).
  - Otherwise `o_v`←0. `o_d` and `o_src` hold their last values.
- Idle cycles: with no transfer from a requester, `ptr` is unchanged. Priority does not rotate on idle cycles.
- Holding output: while `o_v=1` and `o_r=0`, the following are all held stable:
  - `o_d` and `o_src`.
  - `i_r`, which stays all-zero.
- Requester rule: a requester may deassert `i_v` before it is granted. The arbiter must not depend on valid being held, but bench stimulus holds valid until accepted.
- Fairness: any continuously valid requester is granted within `ways` accepted transfers.

## Timing
- Latency: 1 cycle from the requester-accept edge to `o_v`/`o_d` being visible.
- Throughput: 1 transfer per cycle when `o_r` is held at 1.
- Combinational paths into `i_r`: `o_r` → `i_r`, and `i_v` → `i_r`. There is no combinational path from input to `o_*`.
- Reset mid-operation:
  - Asserting reset immediately clears `o_v` (asynchronously). Held data is discarded.
  - `ptr` returns to 0.
  - The first grant after release goes to the lowest-indexed valid requester.

## Test plan
- Reset and empty:
  - Reset asserted while `o_v`=1 -> `o_v`=0, `o_src`=0 and `i_r`=0 in the same cycle.
  - After release with all `i_v`=0 -> `o_v` stays 0 and `ptr` stays 0.
- Rotation with ways=4, all `i_v`=1, `o_r`=1 for 8 cycles -> `o_src` sequence is 0,1,2,3,0,1,2,3 starting 1 cycle after the first accept, with `o_v`=1 continuously.
- Skip idle requesters: `i_v`=4'b1010, ptr=0 -> grants 1, 3, 1, 3. Then with `i_v`=4'b0001 -> grant 0, and `ptr` becomes 1.
- Backpressure:
  - `o_v`=1 with `o_d`=8'hA5, then `o_r`=0 for 5 cycles with all `i_v`=1 -> `i_r`=0 every cycle, and `o_d` holds A5.
  - Then `o_r`=1 -> the next requester loads on the same edge, and `o_v` stays 1.
- Simultaneous drain and fill: `o_v`=1 and `o_r`=1 with only `i_v[2]`=1 and `i_d[2]`=8'h3C -> next cycle `o_d`=3C, `o_src`=2 and `ptr`=3, with no bubble.
- Wrap and data integrity (randomized valids over 1000 cycles; checked against a reference queue model):
  - Every accepted word appears once, in order.
  - Each `o_src` is correct.
  - No requester waits more than 4 accepted transfers while valid.
